// File: rtl/axis_sync_fifo_if.sv
// AXI4-Stream handshake bundle: data, valid and ready.
// The master modport drives data and valid; the slave modport drives ready.
interface axis_sync_fifo_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI4-Stream FIFO built on a circular buffer.
// A word written at one edge is presented on m_axis in the very next cycle.
module axis_sync_fifo #(
  parameter int TDATA_BYTES       = 1,
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 2
) (
  input  logic                     aclk,
  input  logic                     areset,
  axis_sync_fifo_if.slave          s_axis,
  axis_sync_fifo_if.master         m_axis,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     almost_full
);

  localparam int DATA_W = TDATA_BYTES * 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(ALMOST_FULL_LEVEL);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axis_sync_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_af
    $error("axis_sync_fifo: ALMOST_FULL_LEVEL must be in 1..DEPTH");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              in_ready;
  logic              out_valid;
  logic              push;
  logic              pop;

  // Ready and valid come only from the counter (plus reset), so a full FIFO
  // never accepts a word in the same cycle it drains one.
  assign in_ready  = !areset && (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = s_axis.tvalid && in_ready;
  assign pop       = out_valid && m_axis.tready;

  assign s_axis.tready = in_ready;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_valid ? mem[rd_ptr] : '0;
  assign fill_level    = count;
  assign almost_full   = (count >= AF_CNT);

  // NOTE: the storage array has no reset; contents are meaningless until
  // written, and tdata is masked to zero while empty.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= s_axis.tdata;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every read in this block sees the pre-edge value.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always @(posedge aclk) begin
    if (!areset) begin
      assert (count <= FULL_CNT);
      assert (!(pop && count == '0));
      assert (!(push && !pop && count == FULL_CNT));
    end
  end

endmodule
